// File: rtl/i2s_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
// Definitions shared by the I2S receiver and transmitter: default sample width,
// frame width, maximum BCLK edges per channel half, and the channel-tracking
// state enum.
// ----------------------------------------------------------------------------
package i2s_pkg;

    localparam int I2S_SAMPLE_W = 24;
    localparam int I2S_FRAME_W  = 2 * I2S_SAMPLE_W;
    localparam int I2S_MAX_BCLK = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_receiver_if.sv
// ----------------------------------------------------------------------------
// i2s_receiver_if
// Valid/ready frame hand-off from the I2S receiver to its consumer.
//   fifo_data  : received frame {left, right}
//   fifo_valid : fifo_data holds a frame
//   fifo_ready : consumer takes the frame when fifo_valid is also high
// master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface i2s_receiver_if
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_FRAME_W
) ();

    logic [DATA_W-1:0] fifo_data;
    logic              fifo_valid;
    logic              fifo_ready;

    modport master (output fifo_data, output fifo_valid, input fifo_ready);
    modport slave  (input fifo_data, input fifo_valid, output fifo_ready);

endinterface

// File: rtl/i2s_edge_sync.sv
// ----------------------------------------------------------------------------
// i2s_edge_sync
// Brings BCLK, LRCLK and serial data into the clk domain through two-flop
// synchronizers of identical depth (so their relative alignment survives),
// then detects BCLK rising and LRCLK rising/falling edges as one-cycle pulses.
// Ports:
//   clk, rst_n            : system clock, async active-low reset
//   sclk, lrclk, sdata_in : raw I2S inputs
//   sclk_rise             : synchronized BCLK rising edge
//   lrclk_rise/_fall      : synchronized LRCLK edges
//   sdata_sync            : sdata_in, aligned with the synchronized clocks
// ----------------------------------------------------------------------------
module i2s_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic lrclk,
    input  logic sdata_in,
    output logic sclk_rise,
    output logic lrclk_rise,
    output logic lrclk_fall,
    output logic sdata_sync
);

    // Bit order in the vectors: [2] = sclk, [1] = lrclk, [0] = sdata
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    logic [1:0] prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
            prev_reg <= '0;
        end else begin
            meta_reg <= {sclk, lrclk, sdata_in};
            sync_reg <= meta_reg;
            prev_reg <= sync_reg[2:1];
        end
    end

    assign sclk_rise  =  sync_reg[2] & ~prev_reg[1];
    assign lrclk_rise =  sync_reg[1] & ~prev_reg[0];
    assign lrclk_fall = ~sync_reg[1] &  prev_reg[0];
    assign sdata_sync =  sync_reg[0];

endmodule

// File: rtl/i2s_receiver.sv
// ----------------------------------------------------------------------------
// i2s_receiver
// Slave I2S receiver: captures SAMPLE_W bits per channel (MSB first, one BCLK
// after each LRCLK edge) and presents each complete {left, right} frame on a
// single-entry valid/ready output.
// Ports:
//   clk, rst_n            : system clock, async active-low reset
//   sclk, lrclk, sdata_in : I2S BCLK, LRCLK (low = left), serial data
//   fifo (master)         : fifo_data {left,right}, fifo_valid, fifo_ready
//   overflow              : pulse, completed frame dropped (output still held)
//   frame_err             : pulse, malformed channel half discarded
// ----------------------------------------------------------------------------
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = I2S_SAMPLE_W,
    parameter int MAX_BCLK = I2S_MAX_BCLK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdata_in,
    i2s_receiver_if.master        fifo,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(MAX_BCLK + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BCLK);

    logic sclk_rise, lrclk_rise, lrclk_fall, sdata_sync;

    i2s_edge_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .sdata_in   (sdata_in),
        .sclk_rise  (sclk_rise),
        .lrclk_rise (lrclk_rise),
        .lrclk_fall (lrclk_fall),
        .sdata_sync (sdata_sync)
    );

    i2s_state_e                state_reg,     state_next;
    logic [CNT_W-1:0]          cnt_reg,       cnt_next;
    logic [SAMPLE_W-1:0]       shift_reg,     shift_next;
    logic [SAMPLE_W-1:0]       left_reg,      left_next;
    logic                      left_ok_reg,   left_ok_next;
    logic [2*SAMPLE_W-1:0]     data_reg,      data_next;
    logic                      valid_reg,     valid_next;
    logic                      overflow_reg,  overflow_next;
    logic                      frame_err_reg, frame_err_next;
    logic                      frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            left_reg      <= '0;
            left_ok_reg   <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            left_reg      <= left_next;
            left_ok_reg   <= left_ok_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            overflow_reg  <= overflow_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        left_next      = left_reg;
        left_ok_next   = left_ok_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        overflow_next  = 1'b0;
        frame_err_next = 1'b0;
        frame_done     = 1'b0;

        if (valid_reg && fifo.fifo_ready) begin
            valid_next = 1'b0;
        end

        if (lrclk_rise || lrclk_fall) begin
            // The LRCLK edge is handled first; a BCLK rise in the same cycle
            // is the delay slot (count 0) of the half that starts here.
            cnt_next   = {{(CNT_W-1){1'b0}}, sclk_rise};
            shift_next = '0;
            unique case (state_reg)
                IDLE: begin
                    if (lrclk_fall) begin
                        state_next = LEFT;
                    end
                end
                LEFT: begin
                    if (lrclk_rise) begin
                        state_next     = RIGHT;
                        left_next      = shift_reg;
                        left_ok_next   = (cnt_reg >= FULL_CNT);
                        frame_err_next = (cnt_reg < FULL_CNT);
                    end else begin
                        // Edge polarity out of step with the channel: resync
                        state_next     = IDLE;
                        left_ok_next   = 1'b0;
                        frame_err_next = 1'b1;
                    end
                end
                RIGHT: begin
                    left_ok_next = 1'b0;
                    if (lrclk_fall) begin
                        state_next = LEFT;
                        if (cnt_reg < FULL_CNT) begin
                            frame_err_next = 1'b1;
                        end else if (left_ok_reg) begin
                            frame_done = 1'b1;
                        end
                    end else begin
                        state_next     = IDLE;
                        frame_err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (sclk_rise && state_reg != IDLE) begin
            if (cnt_reg == MAX_CNT) begin
                // Too many BCLKs for one half: give up until the next left start
                state_next     = IDLE;
                cnt_next       = '0;
                left_ok_next   = 1'b0;
                frame_err_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg != '0 && cnt_reg <= LAST_BIT) begin
                    shift_next = {shift_reg[SAMPLE_W-2:0], sdata_sync};
                end
            end
        end

        // Single-entry output: a new frame may replace the held one only if
        // the held one is absent or being accepted this very cycle.
        if (frame_done) begin
            if (!valid_reg || fifo.fifo_ready) begin
                data_next  = {left_reg, shift_reg};
                valid_next = 1'b1;
            end else begin
                overflow_next = 1'b1;
            end
        end
    end

    assign fifo.fifo_data  = data_reg;
    assign fifo.fifo_valid = valid_reg;
    assign overflow        = overflow_reg;
    assign frame_err       = frame_err_reg;

endmodule

// File: tb/tb_i2s_receiver.sv
// ----------------------------------------------------------------------------
// tb_i2s_receiver
// Drives I2S traffic into i2s_receiver (bench acts as the I2S master) and
// checks received frames against a scoreboard of expected frames, plus the
// overflow / frame_err pulses and fifo_valid behaviour.
// ----------------------------------------------------------------------------
module tb_i2s_receiver;
    import i2s_pkg::*;

    localparam int SW = 24;
    localparam int HP = 4;   // clk cycles per BCLK half period

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic sclk     = 1'b1;
    logic lrclk    = 1'b1;
    logic sdata_in = 1'b0;
    logic overflow;
    logic frame_err;

    always #5 clk = ~clk;

    i2s_receiver_if #(.DATA_W(2*SW)) fifo_if ();

    i2s_receiver #(.SAMPLE_W(SW), .MAX_BCLK(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdata_in  (sdata_in),
        .fifo      (fifo_if.master),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: records accepted frames and counts pulses, sampled mid-cycle
    logic [2*SW-1:0] got_mem [0:63];
    int   got_n   = 0;
    int   ovf_n   = 0;
    int   ferr_n  = 0;
    int   vrise_n = 0;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_if.fifo_valid && fifo_if.fifo_ready) begin
                got_mem[got_n[5:0]] = fifo_if.fifo_data;
                got_n++;
            end
            if (overflow)  ovf_n++;
            if (frame_err) ferr_n++;
            if (fifo_if.fifo_valid && !valid_prev) vrise_n++;
        end
        valid_prev = fifo_if.fifo_valid;
    end

    logic [2*SW-1:0] exp_q [$];
    int rd_ptr = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One channel half: edge 0 is the delay slot, then MSB..LSB, then zeros
    task automatic send_half(input bit lr, input logic [SW-1:0] d, input int nedges);
        for (int i = 0; i < nedges; i++) begin
            sclk = 1'b0;
            if (i == 0) lrclk = lr;
            sdata_in = (i >= 1 && i <= SW) ? d[SW-i] : 1'b0;
            tick(HP);
            sclk = 1'b1;
            tick(HP);
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
        send_half(1'b0, l, 32);
        send_half(1'b1, r, 32);
    endtask

    // Trailing LRCLK fall that completes the last frame sent
    task automatic end_frame();
        sclk     = 1'b0;
        lrclk    = 1'b0;
        sdata_in = 1'b0;
        tick(2*HP);
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        for (int c = 0; c < budget && got_n < n; c++) tick(1);
        ok = (got_n >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_if.fifo_ready = 1'b1;
        tick(5);
        checks++;
        if (fifo_if.fifo_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", fifo_if.fifo_valid);
        end
        checks++;
        if (fifo_if.fifo_data !== 48'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", fifo_if.fifo_data);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow got %b want 0", overflow);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_frame_err got %b want 0", frame_err);
        end
        $display("reset: valid=%b data=%h", fifo_if.fifo_valid, fifo_if.fifo_data);
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_loopback();
        int bv, bo, bf;
        bit ok;
        logic [2*SW-1:0] e;
        bv = vrise_n; bo = ovf_n; bf = ferr_n;
        fifo_if.fifo_ready = 1'b1;
        send_frame(24'h123456, 24'habcdef);
        exp_q.push_back(48'h123456abcdef);
        end_frame();
        wait_got(rd_ptr + 1, 1000, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++; $display("FAIL loopback_timeout got %0d frames want %0d", got_n, rd_ptr + 1);
        end else begin
            if (got_mem[rd_ptr[5:0]] !== e) begin
                errors++; $display("FAIL loopback_data got %h want %h", got_mem[rd_ptr[5:0]], e);
            end
            $display("loopback: frame %h", got_mem[rd_ptr[5:0]]);
            rd_ptr++;
        end
        tick(20);
        checks++;
        if (vrise_n - bv != 1) begin
            errors++; $display("FAIL loopback_valid_pulses got %0d want 1", vrise_n - bv);
        end
        checks++;
        if (ovf_n - bo != 0) begin
            errors++; $display("FAIL loopback_overflow got %0d want 0", ovf_n - bo);
        end
        checks++;
        if (ferr_n - bf != 0) begin
            errors++; $display("FAIL loopback_frame_err got %0d want 0", ferr_n - bf);
        end
    endtask

    task automatic test_patterns();
        logic [SW-1:0] l_tab [3] = '{24'hFFFFFF, 24'h000000, 24'h7a1cff};
        logic [SW-1:0] r_tab [3] = '{24'hFFFFFF, 24'h000000, 24'h001300};
        bit ok;
        logic [2*SW-1:0] e;
        fifo_if.fifo_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_frame(l_tab[k], r_tab[k]);
            exp_q.push_back({l_tab[k], r_tab[k]});
        end
        end_frame();
        for (int k = 0; k < 3; k++) begin
            wait_got(rd_ptr + 1, 2000, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin
                errors++; $display("FAIL pattern%0d_timeout got %0d frames want %0d", k, got_n, rd_ptr + 1);
            end else begin
                if (got_mem[rd_ptr[5:0]] !== e) begin
                    errors++; $display("FAIL pattern%0d_data got %h want %h", k, got_mem[rd_ptr[5:0]], e);
                end
                $display("pattern %0d: frame %h", k, got_mem[rd_ptr[5:0]]);
                rd_ptr++;
            end
        end
    endtask

    task automatic test_overflow();
        int bo;
        bit ok;
        logic [2*SW-1:0] e;
        bo = ovf_n;
        fifo_if.fifo_ready = 1'b0;
        send_frame(24'h8a1eaa, 24'h001400);
        send_frame(24'h9a1dff, 24'h001500);
        end_frame();
        tick(20);
        checks++;
        if (fifo_if.fifo_valid !== 1'b1) begin
            errors++; $display("FAIL overflow_held_valid got %b want 1", fifo_if.fifo_valid);
        end
        checks++;
        if (fifo_if.fifo_data !== 48'h8a1eaa001400) begin
            errors++; $display("FAIL overflow_held_data got %h want 8a1eaa001400", fifo_if.fifo_data);
        end
        checks++;
        if (ovf_n - bo != 1) begin
            errors++; $display("FAIL overflow_pulses got %0d want 1", ovf_n - bo);
        end
        checks++;
        if (got_n != rd_ptr) begin
            errors++; $display("FAIL overflow_accept_early got %0d frames want %0d", got_n, rd_ptr);
        end
        exp_q.push_back(48'h8a1eaa001400);
        fifo_if.fifo_ready = 1'b1;
        wait_got(rd_ptr + 1, 100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++; $display("FAIL overflow_timeout got %0d frames want %0d", got_n, rd_ptr + 1);
        end else begin
            if (got_mem[rd_ptr[5:0]] !== e) begin
                errors++; $display("FAIL overflow_data got %h want %h", got_mem[rd_ptr[5:0]], e);
            end
            $display("overflow: kept frame %h", got_mem[rd_ptr[5:0]]);
            rd_ptr++;
        end
        tick(20);
        checks++;
        if (got_n != rd_ptr) begin
            errors++; $display("FAIL overflow_dropped got %0d frames want %0d", got_n, rd_ptr);
        end
        checks++;
        if (fifo_if.fifo_valid !== 1'b0) begin
            errors++; $display("FAIL overflow_valid_after got %b want 0", fifo_if.fifo_valid);
        end
    endtask

    task automatic test_truncated();
        int bf, bv;
        bit ok;
        logic [2*SW-1:0] e;
        bf = ferr_n; bv = vrise_n;
        fifo_if.fifo_ready = 1'b1;
        send_half(1'b0, 24'h555555, 10);
        send_half(1'b1, 24'h333333, 32);
        send_frame(24'hc0ffee, 24'h0badf0);
        exp_q.push_back(48'hc0ffee0badf0);
        end_frame();
        wait_got(rd_ptr + 1, 1000, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++; $display("FAIL truncated_timeout got %0d frames want %0d", got_n, rd_ptr + 1);
        end else begin
            if (got_mem[rd_ptr[5:0]] !== e) begin
                errors++; $display("FAIL truncated_next_data got %h want %h", got_mem[rd_ptr[5:0]], e);
            end
            $display("truncated: next frame %h", got_mem[rd_ptr[5:0]]);
            rd_ptr++;
        end
        tick(20);
        checks++;
        if (ferr_n - bf != 1) begin
            errors++; $display("FAIL truncated_frame_err got %0d want 1", ferr_n - bf);
        end
        checks++;
        if (vrise_n - bv != 1) begin
            errors++; $display("FAIL truncated_valid_pulses got %0d want 1", vrise_n - bv);
        end
    endtask

    task automatic test_reset_mid();
        int bv;
        bit ok;
        logic [2*SW-1:0] e;
        fifo_if.fifo_ready = 1'b0;
        send_frame(24'h111111, 24'h222222);
        send_half(1'b0, 24'h333333, 12);
        checks++;
        if (fifo_if.fifo_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_valid_before got %b want 1", fifo_if.fifo_valid);
        end
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (fifo_if.fifo_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_valid_cleared got %b want 0", fifo_if.fifo_valid);
        end
        checks++;
        if (fifo_if.fifo_data !== 48'h0) begin
            errors++; $display("FAIL rstmid_data_cleared got %h want 0", fifo_if.fifo_data);
        end
        rst_n = 1'b1;
        tick(2);
        bv = vrise_n;
        fifo_if.fifo_ready = 1'b1;
        send_half(1'b0, 24'h333333, 20);
        send_half(1'b1, 24'h444444, 32);
        send_frame(24'h5a5a5a, 24'ha5a5a5);
        exp_q.push_back(48'h5a5a5aa5a5a5);
        end_frame();
        wait_got(rd_ptr + 1, 1000, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_timeout got %0d frames want %0d", got_n, rd_ptr + 1);
        end else begin
            if (got_mem[rd_ptr[5:0]] !== e) begin
                errors++; $display("FAIL rstmid_data got %h want %h", got_mem[rd_ptr[5:0]], e);
            end
            $display("reset mid-frame: first frame %h", got_mem[rd_ptr[5:0]]);
            rd_ptr++;
        end
        tick(20);
        checks++;
        if (vrise_n - bv != 1) begin
            errors++; $display("FAIL rstmid_valid_pulses got %0d want 1", vrise_n - bv);
        end
    endtask

    task automatic test_back_to_back();
        int bv, bo;
        bit ok;
        logic [2*SW-1:0] e;
        fifo_if.fifo_ready = 1'b0;
        send_frame(24'h0f0f0f, 24'hf0f0f0);
        send_frame(24'h13579b, 24'h2468ac);
        exp_q.push_back(48'h0f0f0ff0f0f0);
        exp_q.push_back(48'h13579b2468ac);
        bv = vrise_n; bo = ovf_n;
        // LRCLK fall needs two synchronizer stages plus the edge register
        // before the frame completes; raise ready for exactly that edge.
        sclk     = 1'b0;
        lrclk    = 1'b0;
        sdata_in = 1'b0;
        tick(2);
        fifo_if.fifo_ready = 1'b1;
        tick(1);
        checks++;
        if (fifo_if.fifo_valid !== 1'b1 || fifo_if.fifo_data !== 48'h13579b2468ac) begin
            errors++; $display("FAIL b2b_reload got valid=%b data=%h want valid=1 data=13579b2468ac",
                               fifo_if.fifo_valid, fifo_if.fifo_data);
        end
        for (int k = 0; k < 2; k++) begin
            wait_got(rd_ptr + 1, 100, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin
                errors++; $display("FAIL b2b%0d_timeout got %0d frames want %0d", k, got_n, rd_ptr + 1);
            end else begin
                if (got_mem[rd_ptr[5:0]] !== e) begin
                    errors++; $display("FAIL b2b%0d_data got %h want %h", k, got_mem[rd_ptr[5:0]], e);
                end
                $display("back-to-back %0d: frame %h", k, got_mem[rd_ptr[5:0]]);
                rd_ptr++;
            end
        end
        tick(2*HP);
        checks++;
        if (ovf_n - bo != 0) begin
            errors++; $display("FAIL b2b_overflow got %0d want 0", ovf_n - bo);
        end
        checks++;
        if (vrise_n - bv != 0) begin
            errors++; $display("FAIL b2b_valid_gap got %0d re-rises want 0", vrise_n - bv);
        end
    endtask

    initial begin
        fifo_if.fifo_ready = 1'b1;
        test_reset();
        test_loopback();
        test_patterns();
        test_overflow();
        test_truncated();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog_timeout got sim time %0t want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24: bits captured per channel.
REQ-002 SHALL have parameter MAX_BCLK, default 32: maximum rising BCLK edges allowed per channel half.
REQ-003 SHALL have port clk, input, 1: system clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port sclk, input, 1: I2S BCLK, driven by i2s_master.
REQ-006 SHALL have port lrclk, input, 1: I2S LRCLK, driven by i2s_master; low = left, high = right.
REQ-007 SHALL have port sdata_in, input, 1: serial data from the codec ADC.
REQ-008 SHALL have port fifo_data, output, 2*SAMPLE_W: frame as {left, right}.
REQ-009 SHALL have port fifo_valid, output, 1: fifo_data is valid.
REQ-010 SHALL have port fifo_ready, input, 1: downstream accepts the frame.
REQ-011 SHALL have port overflow, output, 1: one-cycle pulse when a completed frame is dropped.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse when a malformed channel half is discarded.

Function
REQ-013 SHALL pass sclk, lrclk and sdata_in through 2-flop synchronizers of identical depth, so their relative alignment is preserved.
REQ-014 SHALL detect sclk rising edges and lrclk edges from the synchronized signals, each detection lasting one clk cycle.
REQ-015 SHALL implement states IDLE, LEFT and RIGHT.
REQ-016 SHALL, in IDLE, ignore all input until an lrclk falling edge, then enter LEFT.
REQ-017 SHALL, in LEFT: on an lrclk rising edge, latch the left shift register and enter RIGHT.
REQ-018 SHALL, in RIGHT: on an lrclk falling edge, finish the frame and enter LEFT.
REQ-019 SHALL count sclk rising edges per half (count 0..MAX_BCLK), with the counter cleared on every lrclk edge.
REQ-020 SHALL ignore the edge at count 0 (the I2S one-BCLK delay), shift in sdata_in MSB first at counts 1..SAMPLE_W, and ignore counts above SAMPLE_W.
REQ-021 SHALL treat a half that ends with count below SAMPLE_W+1 as malformed: pulse frame_err, discard the frame, and continue with the next half.
REQ-022 SHALL treat count exceeding MAX_BCLK within a half as malformed: pulse frame_err and return to IDLE.
REQ-023 SHALL, when a frame completes (lrclk falling edge detected in RIGHT, both halves valid), drive fifo_valid high with fifo_data = {left, right} in the next clk cycle.
REQ-024 SHALL hold fifo_valid and fifo_data stable until the cycle in which fifo_valid and fifo_ready are both high; fifo_valid falls in the following cycle unless a new frame loads.
REQ-025 SHALL, if a frame completes while fifo_valid=1 and fifo_ready=0: drop the new frame, keep the held data, and pulse overflow.
REQ-026 SHALL, if a frame completes in the same cycle the held frame is accepted: load the new frame without overflow, keeping fifo_valid high.
REQ-027 SHALL evaluate simultaneous lrclk and sclk edges in a single cycle as lrclk edge first; that sclk edge becomes count 0 of the new half.

Reset
REQ-028 SHALL, while rst_n=0: hold state IDLE; clear synchronizers, counters and shift registers; and drive fifo_data=0, fifo_valid=0, overflow=0, frame_err=0.
REQ-029 SHALL, on assertion of rst_n mid-frame, abandon any partial frame; after release, wait for the next lrclk falling edge before capturing.

Structure
REQ-030 SHALL take SAMPLE_W, frame width and the state enum from shared package i2s_pkg, which i2s_master also uses.
REQ-031 SHALL place the synchronizers and edge detection in one sub-module, i2s_edge_sync.

Verification
REQ-032 SHALL verify that loopback from i2s_master, sending {24'h123456, 24'habcdef} with fifo_ready=1, yields fifo_data=48'h123456abcdef and exactly one fifo_valid pulse.
REQ-033 SHALL verify that frames FFFFFF/FFFFFF, 000000/000000 and 7a1cff/001300 are received in order with bit-exact data.
REQ-034 SHALL verify that, with fifo_ready=0 for two frames (8a1eaa/001400 then 9a1dff/001500), the first frame is held, overflow pulses once, and the second frame is dropped.
REQ-035 SHALL verify that an lrclk half truncated to 10 BCLK edges produces a frame_err pulse, no fifo_valid, and correct capture of the next full frame.
REQ-036 SHALL verify that rst_n pulsed low mid-left-channel clears fifo_valid, and that the first frame after release is captured only from the next lrclk falling edge.
REQ-037 SHALL verify that a new frame completing in the exact cycle the held frame is accepted gives fifo_valid continuously high, the new data, and no overflow.
